// File: rtl/fm_dac_pkg.sv
// fm_dac_pkg: shared types and constants for the FM modulator DAC serialiser.
//   state_t     - serialiser FSM states
//   FRAME_W     - bits per SPI frame sent to the DAC121S101-class converter
//   PD_NORMAL   - power-down field value for normal operation
//   SCLK_EDGES  - SCLK toggles per frame (two per data bit)
//   EDGE_CNT_W  - width of the SCLK toggle counter
package fm_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int         FRAME_W    = 16;
  localparam logic [1:0] PD_NORMAL  = 2'b00;
  localparam int         SCLK_EDGES = 2 * FRAME_W;
  localparam int         EDGE_CNT_W = $clog2(SCLK_EDGES);

endpackage

// File: rtl/fm_dac_sclk_gen.sv
// fm_dac_sclk_gen: SCLK timing for the DAC serialiser.
// Counts CLK_DIV system clocks per SCLK half-period while enabled and flags
// the terminal count as either a falling or a rising SCLK toggle. SCLK idles
// high, so even-numbered toggles (0, 2, ...) are falls and odd ones are rises.
// Counters are held at zero while disabled, so each frame starts cleanly.
// Ports:
//   clock, reset - system clock, asynchronous active-low reset
//   enable       - high while the serialiser is in SHIFT
//   sclk_fall    - strobe: SCLK goes low on this clock edge
//   sclk_rise    - strobe: SCLK goes high on this clock edge
//   edge_cnt     - number of SCLK toggles already made in this frame
module fm_dac_sclk_gen
  import fm_dac_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  sclk_fall,
  output logic                  sclk_rise,
  output logic [EDGE_CNT_W-1:0] edge_cnt
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tc;

  assign tc        = enable && (div_cnt == DIV_LAST);
  assign sclk_fall = tc && !edge_cnt[0];
  assign sclk_rise = tc && edge_cnt[0];

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else if (!enable) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else if (tc) begin
      div_cnt  <= '0;
      edge_cnt <= edge_cnt + 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fm_dac_spi.sv
// fm_dac_spi: serialiser between the CORDIC sine stage and the PMOD DAC.
// Takes one offset-binary sample per valid/ready handshake and sends its top
// DAC_W bits as a 16-bit SPI frame {2'b00, PD_NORMAL, code}, MSB first. DIN
// changes on SCLK rise; the DAC samples on SCLK fall. The DAC holds its last
// value between frames, so the sample rate is set by the upstream stage.
// Optional feature: define FM_DAC_LED_EN to add output led[7:0], the top
// byte of each accepted sample, for a board LED bar.
// Ports:
//   clock, reset - system clock, asynchronous active-low reset
//   s_data       - SAMPLE_W-bit sample, held stable until accepted
//   s_valid      - sample valid
//   s_ready      - ready to accept (IDLE only), registered
//   dac_sync_n   - DAC frame sync, active low
//   dac_sclk     - SPI clock, idles high
//   dac_din      - SPI data, MSB first
//   busy         - high from accept until the end of the inter-frame gap
//   frame_done   - one-cycle pulse on the clock where dac_sync_n rises
//   led          - (FM_DAC_LED_EN only) s_data[15:8] captured at accept
module fm_dac_spi
  import fm_dac_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int DAC_W      = 12,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                dac_sync_n,
  output logic                dac_sclk,
  output logic                dac_din,
  output logic                busy,
  output logic                frame_done
`ifdef FM_DAC_LED_EN
  ,
  output logic [7:0]          led
`endif
);

  // SYNC must stay high for GAP_CYCLES clocks between frames. The final one of
  // those clocks is the IDLE clock in which the next sample can be accepted,
  // so the GAP state itself lasts GAP_CYCLES-1 clocks (none when GAP_CYCLES
  // is 1, in which case SHIFT returns straight to IDLE).
  localparam int                GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  localparam logic [EDGE_CNT_W-1:0] LAST_EDGE = EDGE_CNT_W'(SCLK_EDGES - 1);

  state_t                  state, state_d;
  logic                    accept;
  logic                    frame_end;
  logic [FRAME_W-1:0]      shift_reg;
  logic [FRAME_W-1:0]      frame_in;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    sclk_fall;
  logic                    sclk_rise;
  logic [EDGE_CNT_W-1:0]   edge_cnt;
  logic                    unused_sample_bits;

  assign frame_in = {{(FRAME_W - 2 - DAC_W){1'b0}}, PD_NORMAL, s_data[SAMPLE_W-1 -: DAC_W]};

  // The low sample bits are below DAC resolution and intentionally dropped.
  assign unused_sample_bits = ^s_data[SAMPLE_W-DAC_W-1:0];

  fm_dac_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clock     (clock),
    .reset     (reset),
    .enable    (state == ST_SHIFT),
    .sclk_fall (sclk_fall),
    .sclk_rise (sclk_rise),
    .edge_cnt  (edge_cnt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (s_valid && s_ready) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // The final rising toggle leaves SCLK high with all 16 falls delivered.
        if (sclk_rise && (edge_cnt == LAST_EDGE)) begin
          frame_end = 1'b1;
          state_d   = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      dac_sync_n <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_din    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      s_ready    <= (state_d == ST_IDLE);
      busy       <= (state_d != ST_IDLE);
      dac_sync_n <= (state_d != ST_SHIFT);
      frame_done <= frame_end;
      if (state_d != ST_SHIFT)          dac_sclk <= 1'b1;
      else if (sclk_fall || sclk_rise) dac_sclk <= sclk_rise;
      if (accept)                      dac_din <= frame_in[FRAME_W-1];
      else if (state_d != ST_SHIFT)    dac_din <= 1'b0;
      else if (sclk_rise)              dac_din <= shift_reg[FRAME_W-2];
    end
  end

  // NOTE: the datapath registers are reset too; they are few, and it keeps a
  // post-reset frame independent of whatever was abandoned mid-shift.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      gap_cnt   <= '0;
    end else begin
      if (accept)                               shift_reg <= frame_in;
      else if ((state == ST_SHIFT) && sclk_rise) shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
      if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                 gap_cnt <= '0;
    end
  end

`ifdef FM_DAC_LED_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      led <= '0;
    else if (accept) led <= s_data[SAMPLE_W-1 -: 8];
  end
`endif

endmodule

// File: tb/tb_fm_dac_spi.sv
// tb_fm_dac_spi: directed bench for fm_dac_spi.
// A default-parameter instance is exercised with single frames, back-to-back
// frames, a sample offered mid-frame and a mid-frame reset; a second instance
// with CLK_DIV=2, GAP_CYCLES=1 checks the short frame timing. A small DAC
// model shifts DIN in on each SCLK fall while SYNC is low.
module tb_fm_dac_spi;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, dac_sync_n, dac_sclk, dac_din, busy, frame_done;
  logic [15:0] f_data = '0;
  logic        f_valid = 1'b0;
  logic        f_ready, f_sync_n, f_sclk, f_din, f_busy, f_done;
`ifdef FM_DAC_LED_EN
  logic [7:0]  led;
  logic [7:0]  f_led;
`endif

  always #5 clock = ~clock;

  fm_dac_spi dut (
    .clock      (clock),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .dac_sync_n (dac_sync_n),
    .dac_sclk   (dac_sclk),
    .dac_din    (dac_din),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef FM_DAC_LED_EN
    ,
    .led        (led)
`endif
  );

  fm_dac_spi #(.CLK_DIV(2), .GAP_CYCLES(1)) dut_fast (
    .clock      (clock),
    .reset      (reset),
    .s_data     (f_data),
    .s_valid    (f_valid),
    .s_ready    (f_ready),
    .dac_sync_n (f_sync_n),
    .dac_sclk   (f_sclk),
    .dac_din    (f_din),
    .busy       (f_busy),
    .frame_done (f_done)
`ifdef FM_DAC_LED_EN
    ,
    .led        (f_led)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle stamps and event logs, sampled 1 ns after each rising edge.
  int   cyc = 0;
  logic prev_sync = 1'b1, f_prev_sync = 1'b1;
  int   fall_q[$], rise_q[$], done_q[$];
  int   f_fall_q[$], f_rise_q[$], f_done_q[$];
  int   ready_in_shift = 0;

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    #1;
    if (prev_sync === 1'b1 && dac_sync_n === 1'b0) fall_q.push_back(cyc);
    if (prev_sync === 1'b0 && dac_sync_n === 1'b1) rise_q.push_back(cyc);
    if (frame_done === 1'b1) done_q.push_back(cyc);
    if (dac_sync_n === 1'b0 && s_ready !== 1'b0) ready_in_shift++;
    prev_sync = dac_sync_n;
    if (f_prev_sync === 1'b1 && f_sync_n === 1'b0) f_fall_q.push_back(cyc);
    if (f_prev_sync === 1'b0 && f_sync_n === 1'b1) f_rise_q.push_back(cyc);
    if (f_done === 1'b1) f_done_q.push_back(cyc);
    f_prev_sync = f_sync_n;
  end

  // DAC model: shift DIN in on SCLK falls inside a frame, log at SYNC rise.
  logic [15:0] rx = '0;
  int          nfall = 0;
  logic [15:0] rx_q[$];
  int          nfall_q[$];

  always @(negedge dac_sclk) if (dac_sync_n === 1'b0) begin
    rx = {rx[14:0], dac_din};
    nfall++;
  end
  always @(negedge dac_sync_n) begin
    rx    = '0;
    nfall = 0;
  end
  always @(posedge dac_sync_n) begin
    rx_q.push_back(rx);
    nfall_q.push_back(nfall);
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_mon();
    fall_q.delete();   rise_q.delete();   done_q.delete();
    f_fall_q.delete(); f_rise_q.delete(); f_done_q.delete();
    rx_q.delete();     nfall_q.delete();
    ready_in_shift = 0;
  endtask

  task automatic wait_sync_low(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      if (dac_sync_n === 1'b0) ok = 1'b1;
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic wait_accepts(input int n, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      if (fall_q.size() >= n) ok = 1'b1;
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      if (s_ready === 1'b1) ok = 1'b1;
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic f_wait_accepts(input int n, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      if (f_fall_q.size() >= n) ok = 1'b1;
    end
    check(tag, ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while reset is held low.
    #22;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_sync_n", dac_sync_n, 1'b1);
    check("rst_sclk", dac_sclk, 1'b1);
    check("rst_din", dac_din, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
`ifdef FM_DAC_LED_EN
    check("rst_led", led, 8'h00);
`endif
    step();
    reset = 1'b1;
    repeat (3) step();
    check("idle_s_ready", s_ready, 1'b1);
    clear_mon();

    // Single sample 0xABCD -> frame 0x0ABC.
    s_data  = 16'hABCD;
    s_valid = 1'b1;
    wait_sync_low("a1_accept");
    s_valid = 1'b0;
    check("a1_busy", busy, 1'b1);
    check("a1_s_ready", s_ready, 1'b0);
    check("a1_din_msb", dac_din, 1'b0);
    check("a1_sclk_idle", dac_sclk, 1'b1);
    repeat (3) step();
    check("a1_sclk_before_fall", dac_sclk, 1'b1);
    step();
    check("a1_sclk_first_fall", dac_sclk, 1'b0);
    wait_ready("a1_done");
    step();
    check("a1_n_frames", rx_q.size(), 1);
    check("a1_dac_frame", rx_q[0], 16'h0ABC);
    check("a1_n_falls", nfall_q[0], 16);
    check("a1_sync_low", rise_q[0] - fall_q[0], 128);
    check("a1_n_done", done_q.size(), 1);
    check("a1_done_at_rise", done_q[0], rise_q[0]);
    clear_mon();

    // s_valid held: 0x0000 then 0xFFF0, accepts 130 clocks apart.
    s_data  = 16'h0000;
    s_valid = 1'b1;
    wait_sync_low("b2b_accept0");
    s_data = 16'hFFF0;
    wait_accepts(2, "b2b_accept1");
    s_valid = 1'b0;
    wait_ready("b2b_done");
    step();
    check("b2b_period", fall_q[1] - fall_q[0], 130);
    check("b2b_code0", rx_q[0], 16'h0000);
    check("b2b_code1", rx_q[1], 16'h0FFF);
    check("b2b_falls1", nfall_q[1], 16);
    clear_mon();

    // Sample offered mid-frame waits for IDLE and arrives unchanged.
    s_data  = 16'h1230;
    s_valid = 1'b1;
    wait_sync_low("wait_accept0");
    s_valid = 1'b0;
    repeat (20) step();
    s_data  = 16'h5670;
    s_valid = 1'b1;
    step();
    check("wait_ready_low", s_ready, 1'b0);
    wait_accepts(2, "wait_accept1");
    s_valid = 1'b0;
    wait_ready("wait_done");
    step();
    check("wait_no_ready_in_shift", ready_in_shift, 0);
    check("wait_period", fall_q[1] - fall_q[0], 130);
    check("wait_code0", rx_q[0], 16'h0123);
    check("wait_code1", rx_q[1], 16'h0567);
    clear_mon();

    // Reset at clock 60 of a frame: frame 0x0F00, SCLK low and DIN=bit8=1.
    s_data  = 16'hF000;
    s_valid = 1'b1;
    wait_sync_low("rst_mid_accept");
    s_valid = 1'b0;
    repeat (60) step();
    check("pre_rst_sync", dac_sync_n, 1'b0);
    check("pre_rst_sclk", dac_sclk, 1'b0);
    check("pre_rst_din", dac_din, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_sync", dac_sync_n, 1'b1);
    check("mid_rst_sclk", dac_sclk, 1'b1);
    check("mid_rst_din", dac_din, 1'b0);
    check("mid_rst_s_ready", s_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
    clear_mon();
    s_data  = 16'h9990;
    s_valid = 1'b1;
    wait_sync_low("post_rst_accept");
    s_valid = 1'b0;
    wait_ready("post_rst_done");
    step();
    check("post_rst_code", rx_q[0], 16'h0999);
    check("post_rst_falls", nfall_q[0], 16);
    check("post_rst_sync_low", rise_q[0] - fall_q[0], 128);
    clear_mon();

    // CLK_DIV=2, GAP_CYCLES=1: SYNC low 64 clocks, accept period 65.
    f_data  = 16'h1110;
    f_valid = 1'b1;
    f_wait_accepts(1, "fast_accept0");
    f_data = 16'h2220;
    f_wait_accepts(2, "fast_accept1");
    f_valid = 1'b0;
    repeat (80) step();
    check("fast_sync_low", f_rise_q[0] - f_fall_q[0], 64);
    check("fast_period", f_fall_q[1] - f_fall_q[0], 65);
    check("fast_n_done", f_done_q.size(), 2);
    check("fast_idle_ready", f_ready, 1'b1);

`ifdef FM_DAC_LED_EN
    // LED bar shows the top byte of the accepted sample.
    clear_mon();
    s_data  = 16'h8123;
    s_valid = 1'b1;
    wait_sync_low("led_accept");
    s_valid = 1'b0;
    check("led_value", led, 8'h81);
    wait_ready("led_done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
